// File: rtl/stop_watch_core.sv
// Parametrised BCD stopwatch/countdown engine with preset load, up/down mode and wrap/done flags.
// Optional lap capture is built only when SW_LAP_EN is defined.
module stop_watch_core #(
    parameter int NDIG = 4,
    parameter int DVSR = 5_000_000,
    parameter int PW   = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              clr,
    input  logic              up,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              lap,
    output logic [4*NDIG-1:0] d,
    output logic [4*NDIG-1:0] lap_d,
    output logic              lap_valid,
    output logic              tick,
    output logic              wrap,
    output logic              done
);

    localparam int W = 4 * NDIG;
    localparam logic [PW-1:0] PMAX = PW'(DVSR - 1);

    logic [PW-1:0] presc;
    logic          tick_int;

    assign tick_int = go && (presc == PMAX);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic a;
        a = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                a = 1'b0;
            end
        end
        return a;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            d     <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clr) begin
                presc <= '0;
                d     <= '0;
                done  <= 1'b0;
            end else if (load) begin
                presc <= '0;
                d     <= bcd_sat(load_val);
                done  <= 1'b0;
            end else if (go) begin
                presc <= tick_int ? '0 : presc + 1'b1;
                if (tick_int) begin
                    tick <= 1'b1;
                    if (up) begin
                        d    <= bcd_inc(d);
                        wrap <= all_nines(d);
                        done <= 1'b0;
                    end else if (d == '0) begin
                        // Countdown parked at zero: hold, keep done asserted, still pulse tick.
                        done <= 1'b1;
                    end else begin
                        d <= bcd_dec(d);
                        if (d == W'(1)) begin
                            done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef SW_LAP_EN
    // Captures the register value before any same-cycle tick update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_d     <= '0;
            lap_valid <= 1'b0;
        end else if (clr) begin
            lap_d     <= '0;
            lap_valid <= 1'b0;
        end else if (lap) begin
            lap_d     <= d;
            lap_valid <= 1'b1;
        end
    end
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign lap_d      = '0;
    assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stop_watch_core.sv
// Self-checking bench for stop_watch_core (NDIG=4, DVSR=4) against a decimal-integer reference model.
module tb_stop_watch_core;

    localparam int NDIG = 4;
    localparam int DVSR = 4;
    localparam int PW   = 3;

    logic        clk = 1'b0;
    logic        reset, go, clr, up, load, lap;
    logic [15:0] load_val;
    logic [15:0] d, lap_d;
    logic        lap_valid, tick, wrap, done;

    int checks = 0;
    int errors = 0;

    int m_val, m_presc, m_lap_val;
    logic m_done, m_tick, m_wrap, m_lap_valid;

    stop_watch_core #(.NDIG(NDIG), .DVSR(DVSR), .PW(PW)) dut (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .load(load),
        .load_val(load_val), .lap(lap), .d(d), .lap_d(lap_d), .lap_valid(lap_valid),
        .tick(tick), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sat_value(input logic [15:0] lv);
        int v, p, n;
        v = 0;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_val = 0; m_presc = 0; m_lap_val = 0;
        m_done = 0; m_tick = 0; m_wrap = 0; m_lap_valid = 0;
    endtask

    // Advance one clock and apply the counting rules to the integer model.
    task automatic model_cycle();
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            m_tick = 0;
            m_wrap = 0;
`ifdef SW_LAP_EN
            if (clr) begin
                m_lap_val = 0; m_lap_valid = 0;
            end else if (lap) begin
                m_lap_val = m_val; m_lap_valid = 1;
            end
`endif
            if (clr) begin
                m_val = 0; m_presc = 0; m_done = 0;
            end else if (load) begin
                m_val = sat_value(load_val); m_presc = 0; m_done = 0;
            end else if (go) begin
                if (m_presc == DVSR - 1) begin
                    m_presc = 0;
                    m_tick = 1;
                    if (up) begin
                        m_done = 0;
                        if (m_val == 9999) begin
                            m_val = 0; m_wrap = 1;
                        end else begin
                            m_val = m_val + 1;
                        end
                    end else if (m_val == 0) begin
                        m_done = 1;
                    end else begin
                        m_val = m_val - 1;
                        if (m_val == 0) m_done = 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; go = 0; clr = 0; up = 1; load = 0; lap = 0; load_val = '0;
        model_reset();
        model_cycle();
        model_cycle();
        reset = 0;
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_d got %h want 0000", d); end
        checks++; if (lap_d !== 16'h0000) begin errors++; $display("FAIL reset_lap_d got %h want 0000", lap_d); end
        checks++; if ({lap_valid, tick, wrap, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {lap_valid, tick, wrap, done});
        end
    endtask

    task automatic test_count_up();
        go = 1; up = 1;
        for (int c = 1; c <= 40; c++) begin
            model_cycle();
            checks++; if (d !== to_bcd(m_val)) begin errors++; $display("FAIL up_d cyc %0d got %h want %h", c, d, to_bcd(m_val)); end
            checks++; if (tick !== ((c % DVSR) == 0)) begin errors++; $display("FAIL up_tick cyc %0d got %b want %b", c, tick, (c % DVSR) == 0); end
        end
        checks++; if (d !== 16'h0010) begin errors++; $display("FAIL up_10_ticks got %h want 0010", d); end
    endtask

    task automatic test_wrap();
        int nwrap;
        nwrap = 0;
        load = 1; load_val = 16'h9998; up = 1; go = 1;
        model_cycle();
        load = 0;
        for (int c = 1; c <= 2 * DVSR; c++) begin
            model_cycle();
            if (wrap === 1'b1) nwrap++;
            checks++; if (d !== to_bcd(m_val)) begin errors++; $display("FAIL wrap_d cyc %0d got %h want %h", c, d, to_bcd(m_val)); end
            checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL wrap_flag cyc %0d got %b want %b", c, wrap, m_wrap); end
            if (c == DVSR) begin
                checks++; if (d !== 16'h9999) begin errors++; $display("FAIL wrap_first got %h want 9999", d); end
            end
        end
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wrap_final got %h want 0000", d); end
        checks++; if (nwrap != 1) begin errors++; $display("FAIL wrap_count got %0d want 1", nwrap); end
    endtask

    task automatic test_down_done();
        load = 1; load_val = 16'h0002; up = 0; go = 1;
        model_cycle();
        load = 0;
        for (int c = 1; c <= 3 * DVSR; c++) begin
            model_cycle();
            checks++; if (d !== to_bcd(m_val)) begin errors++; $display("FAIL down_d cyc %0d got %h want %h", c, d, to_bcd(m_val)); end
            checks++; if ({tick, wrap, done} !== {m_tick, m_wrap, m_done}) begin
                errors++; $display("FAIL down_flags cyc %0d got %b want %b", c, {tick, wrap, done}, {m_tick, m_wrap, m_done});
            end
        end
        checks++; if ({d, done, tick, wrap} !== {16'h0000, 3'b110}) begin
            errors++; $display("FAIL down_held got d=%h done=%b tick=%b wrap=%b want 0000 1 1 0", d, done, tick, wrap);
        end
    endtask

    task automatic test_load();
        int n;
        load = 1; load_val = 16'h0A0F; go = 1; up = 1;
        model_cycle();
        load = 0;
        checks++; if (d !== 16'h0909) begin errors++; $display("FAIL load_sat got %h want 0909", d); end
        n = 0;
        while (m_presc != DVSR - 1 && n < 2 * DVSR) begin
            model_cycle();
            n++;
        end
        load = 1; load_val = 16'h1234;
        model_cycle();
        load = 0;
        checks++; if (d !== 16'h1234 || d !== to_bcd(m_val)) begin errors++; $display("FAIL load_on_tick got %h want 1234", d); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL load_on_tick_pulse got %b want 0", tick); end
    endtask

    task automatic test_lap();
        int n;
        load = 1; load_val = 16'h0123; go = 1; up = 1;
        model_cycle();
        load = 0;
        n = 0;
        while (m_presc != DVSR - 1 && n < 2 * DVSR) begin
            model_cycle();
            n++;
        end
        lap = 1;
        model_cycle();
        lap = 0;
        checks++; if (d !== 16'h0124) begin errors++; $display("FAIL lap_d_live got %h want 0124", d); end
`ifdef SW_LAP_EN
        checks++; if (lap_d !== 16'h0123 || lap_valid !== 1'b1) begin
            errors++; $display("FAIL lap_capture got %h/%b want 0123/1", lap_d, lap_valid);
        end
`else
        checks++; if (lap_d !== 16'h0000 || lap_valid !== 1'b0) begin
            errors++; $display("FAIL lap_disabled got %h/%b want 0000/0", lap_d, lap_valid);
        end
`endif
        clr = 1; lap = 1;
        model_cycle();
        clr = 0; lap = 0;
        checks++; if ({d, lap_d, lap_valid, done, tick, wrap} !== '0) begin
            errors++; $display("FAIL clr_all got d=%h lap_d=%h flags=%b want zeros", d, lap_d, {lap_valid, done, tick, wrap});
        end
    endtask

    task automatic test_pause();
        int n;
        clr = 1;
        model_cycle();
        clr = 0; go = 1; up = 1;
        model_cycle();
        model_cycle();
        go = 0;
        for (int c = 0; c < 10; c++) begin
            model_cycle();
            checks++; if (tick !== 1'b0 || d !== 16'h0000) begin errors++; $display("FAIL pause_hold cyc %0d got tick=%b d=%h want 0 0000", c, tick, d); end
        end
        go = 1;
        n = 0;
        do begin
            model_cycle();
            n++;
        end while (tick !== 1'b1 && n < 20);
        checks++; if (n != 2) begin errors++; $display("FAIL pause_resume got %0d clk want 2", n); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            go       = ($urandom_range(0, 9) != 0);
            up       = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 39) == 0);
            lap      = ($urandom_range(0, 19) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? 16'(to_bcd($urandom_range(0, 3))) : 16'($urandom);
            model_cycle();
            checks++; if (d !== to_bcd(m_val)) begin errors++; $display("FAIL rand_d cyc %0d got %h want %h", c, d, to_bcd(m_val)); end
            checks++; if ({tick, wrap, done} !== {m_tick, m_wrap, m_done}) begin
                errors++; $display("FAIL rand_flags cyc %0d got %b want %b", c, {tick, wrap, done}, {m_tick, m_wrap, m_done});
            end
            checks++; if (lap_d !== to_bcd(m_lap_val) || lap_valid !== m_lap_valid) begin
                errors++; $display("FAIL rand_lap cyc %0d got %h/%b want %h/%b", c, lap_d, lap_valid, to_bcd(m_lap_val), m_lap_valid);
            end
        end
        clr = 0; load = 0; lap = 0;
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 16'h0555; go = 1; up = 1; lap = 1;
        model_cycle();
        load = 0; lap = 0;
        model_cycle();
        model_cycle();
        #2;
        reset = 1;
        #1;
        checks++; if (d !== 16'h0000 || lap_d !== 16'h0000) begin errors++; $display("FAIL async_reset_d got %h/%h want 0000/0000", d, lap_d); end
        checks++; if ({lap_valid, tick, wrap, done} !== 4'b0000) begin
            errors++; $display("FAIL async_reset_flags got %b want 0000", {lap_valid, tick, wrap, done});
        end
        model_reset();
        model_cycle();
        reset = 0;
        for (int c = 0; c < 2 * DVSR; c++) begin
            model_cycle();
            checks++; if (d !== to_bcd(m_val) || tick !== m_tick) begin errors++; $display("FAIL post_reset cyc %0d got %h/%b want %h/%b", c, d, tick, to_bcd(m_val), m_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_down_done();
        test_load();
        test_lap();
        test_pause();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
